host_mmio_monitor: RTL and testbench

- Synthesizable, parametrised successor to the bench-side console/exit/watchdog logic.
- Snoops the core's data-memory write channel and claims writes to a configurable MMIO window:
  - an NCHAN-channel character console, buffered in a FIFO and drained over a valid/ready stream;
  - an exit register with drain-before-done sequencing;
  - a PC-stagnation watchdog;
  - an out-of-range write detector.
- Sits between `riscv` and the data RAM, gating the RAM write strobe for claimed addresses.

---
 rtl/host_mmio_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/host_mmio_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_host_mmio_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_mmio_pkg.sv
// host_mmio_pkg
// Shared definitions for the host MMIO monitor. It holds the register offsets
// inside the MMIO window, the window size, the exit code reported on a
// watchdog timeout, the run-state enum and a width helper used for
// parameter-derived signal widths.
package host_mmio_pkg;

  // Register offsets relative to BASE.
  localparam logic [31:0] OFS_PUTC0    = 32'h0000_001C;  // legacy alias of PUTC(0)
  localparam logic [31:0] OFS_EXIT     = 32'h0000_002C;
  localparam logic [31:0] OFS_CHAN     = 32'h0000_0100;  // PUTC(n) at OFS_CHAN + 4n
  localparam logic [31:0] WIN_SIZE     = 32'h0000_0200;  // claimed window [BASE, BASE+WIN_SIZE)

  localparam logic [31:0] EXIT_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Widths that come from $clog2 can collapse to 0 (NCHAN=1) or be too
  // narrow for a comfortable counter; this clamps them to a floor.
  function automatic int unsigned width_at_least(input int unsigned w,
                                                 input int unsigned floor_w);
    return (w < floor_w) ? floor_w : w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with flop storage and a combinational read of the head
// entry. Pointers carry one extra MSB so that full and empty are
// distinguishable without a separate counter. The read port shows zero while
// the FIFO is empty, so the unreset storage never leaks to the outputs.
//
// Ports:
//   clk, resetb : clock, synchronous active-low reset
//   push, wdata : write request and data; ignored when full unless popping
//   pop         : remove the head entry; ignored when empty
//   rdata       : head entry (zero while empty)
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is fine when the head leaves on the same edge:
  // the write lands in the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage has no reset; equal pointers already mark it empty
  // and rdata is masked, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/host_mmio_monitor.sv
// host_mmio_monitor
// Snoops the core's data-memory write channel and claims writes that fall in
// the MMIO window [BASE, BASE+0x200). Claimed writes never reach the RAM.
// Inside the window it provides an NCHAN-channel character console (buffered
// in a FIFO and drained over valid/ready), an exit register that waits for
// the console to drain before reporting done, a PC-stagnation watchdog and
// an out-of-range write detector for unclaimed writes at or above MEM_TOP.
//
// Ports:
//   clk, resetb            : clock, synchronous active-low reset
//   stall, if_pc           : core stall and fetch PC (watchdog inputs)
//   dmem_wready/waddr/wdata/wstrb : snooped core write channel
//   ram_wready             : write strobe to the RAM, claimed addresses masked
//   out_valid/ready/data/chan : console character stream
//   exit_valid, exit_code  : run finished (sticky) and its code
//   timeout                : watchdog fired (sticky)
//   range_err, err_addr    : illegal write seen (sticky) and its first address
//   drop_cnt               : characters lost to a full FIFO (saturating)
module host_mmio_monitor
  import host_mmio_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h9000_0000,
  parameter int unsigned NCHAN      = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 100,
  parameter logic [31:0] MEM_TOP    = 32'h0004_0000,
  localparam int unsigned CW        = width_at_least($clog2(NCHAN), 1)
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          stall,
  input  logic [31:0]   if_pc,
  input  logic          dmem_wready,
  input  logic [31:0]   dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          ram_wready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [CW-1:0] out_chan,
  output logic          exit_valid,
  output logic [31:0]   exit_code,
  output logic          timeout,
  output logic          range_err,
  output logic [31:0]   err_addr,
  output logic [15:0]   drop_cnt
);

  localparam int unsigned WDW = width_at_least($clog2(TIMEOUT + 1), 8);
  localparam int unsigned FW  = CW + 8;

  // ---------------------------------------------------------------- decode
  logic [31:0]   ofs;
  logic          in_win;
  logic          hit_chan;
  logic          hit_alias;
  logic          putc_hit;
  logic          exit_hit;
  logic          range_hit;
  logic [CW-1:0] putc_chan;
  logic          unused_wstrb;

  // Console writes are byte-agnostic: the low byte of wdata is the character.
  assign unused_wstrb = ^dmem_wstrb;

  // Unsigned wrap makes addresses below BASE look huge, so one compare
  // covers both ends of the window.
  assign ofs    = dmem_waddr - BASE;
  assign in_win = ofs < WIN_SIZE;

  assign hit_chan  = in_win && (ofs >= OFS_CHAN) &&
                     (ofs < OFS_CHAN + 32'(4 * NCHAN)) && (ofs[1:0] == 2'b00);
  assign hit_alias = (ofs == OFS_PUTC0);
  // OFS_CHAN has no bits in [5:2], so those bits of the offset are n.
  assign putc_chan = hit_alias ? '0 : ofs[2 +: CW];

  assign putc_hit  = dmem_wready && (hit_chan || hit_alias);
  assign exit_hit  = dmem_wready && (ofs == OFS_EXIT);
  assign range_hit = dmem_wready && !in_win && (dmem_waddr >= MEM_TOP);

  assign ram_wready = dmem_wready && !in_win;

  // ------------------------------------------------------------------ state
  state_e      state_q, state_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        timeout_q, timeout_d;
  logic        range_err_q, range_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] prev_pc_q, prev_pc_d;
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

  logic          wd_fire;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rdata;

  // ------------------------------------------------------------------- FIFO
  assign fifo_push = putc_hit && (state_q == RUN);
  assign fifo_pop  = out_valid && out_ready;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  ({putc_chan, dmem_wdata[7:0]}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[7:0];
  assign out_chan  = fifo_rdata[FW-1:8];

  // --------------------------------------------------------------- watchdog
  assign wd_fire = (state_q == RUN) && (wd_cnt_q == WDW'(TIMEOUT));

  always_comb begin
    prev_pc_d = if_pc;
    wd_cnt_d  = wd_cnt_q;
    if (state_q != RUN || if_pc != prev_pc_q) begin
      wd_cnt_d = '0;
    end else if (!stall) begin
      // Never exceeds TIMEOUT in RUN: the fire moves the FSM out of RUN.
      wd_cnt_d = wd_cnt_q + WDW'(1);
    end
  end

  // -------------------------------------------------------- FSM and flags
  // NOTE: every variable gets a default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    exit_code_d = exit_code_q;
    timeout_d   = timeout_q;
    drop_cnt_d  = drop_cnt_q;

    unique case (state_q)
      RUN: begin
        if (exit_hit) begin
          exit_code_d = dmem_wdata;
          state_d     = DRAIN;
        end else if (wd_fire) begin
          timeout_d   = 1'b1;
          exit_code_d = EXIT_TIMEOUT;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Only RUN pushes, so writes discarded in DRAIN/DONE never count.
    if (fifo_push && fifo_full && !fifo_pop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    range_err_d = range_err_q || range_hit;
    err_addr_d  = (range_hit && !range_err_q) ? dmem_waddr : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q     <= RUN;
      exit_code_q <= '0;
      timeout_q   <= 1'b0;
      range_err_q <= 1'b0;
      err_addr_q  <= '0;
      drop_cnt_q  <= '0;
      prev_pc_q   <= '0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      exit_code_q <= exit_code_d;
      timeout_q   <= timeout_d;
      range_err_q <= range_err_d;
      err_addr_q  <= err_addr_d;
      drop_cnt_q  <= drop_cnt_d;
      prev_pc_q   <= prev_pc_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign exit_valid = (state_q == DONE);
  assign exit_code  = exit_code_q;
  assign timeout    = timeout_q;
  assign range_err  = range_err_q;
  assign err_addr   = err_addr_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_host_mmio_monitor.sv
// tb_host_mmio_monitor
// Directed bench for host_mmio_monitor with default parameters. Stimulus is
// a linear sequence of steps; inputs change 1 time unit after each rising
// edge, and outputs are checked there too. A negedge monitor records every
// accepted console beat as {chan, data} for later comparison.
module tb_host_mmio_monitor;

  localparam logic [31:0] BASE     = 32'h9000_0000;
  localparam logic [31:0] A_PUTC0  = BASE + 32'h1C;
  localparam logic [31:0] A_PUTC1  = BASE + 32'h104;
  localparam logic [31:0] A_EXIT   = BASE + 32'h2C;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        dmem_wready = 1'b0;
  logic [31:0] dmem_waddr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic        ram_wready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [0:0]  out_chan;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic        timeout;
  logic        range_err;
  logic [31:0] err_addr;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  logic pc_move = 1'b1;
  logic [15:0] rx[$];

  always #5 clk = ~clk;

  host_mmio_monitor #(
    .BASE       (BASE),
    .NCHAN      (2),
    .FIFO_DEPTH (16),
    .TIMEOUT    (100),
    .MEM_TOP    (32'h0004_0000)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .stall       (stall),
    .if_pc       (if_pc),
    .dmem_wready (dmem_wready),
    .dmem_waddr  (dmem_waddr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .ram_wready  (ram_wready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .exit_valid  (exit_valid),
    .exit_code   (exit_code),
    .timeout     (timeout),
    .range_err   (range_err),
    .err_addr    (err_addr),
    .drop_cnt    (drop_cnt)
  );

  always @(negedge clk) begin
    if (resetb && out_valid && out_ready) rx.push_back({7'd0, out_chan, out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; a moving PC keeps the watchdog quiet outside its own test.
  task automatic step();
    @(posedge clk);
    #1;
    if (pc_move) if_pc = if_pc + 32'd4;
  endtask

  task automatic do_reset();
    dmem_wready = 1'b0;
    out_ready   = 1'b0;
    stall       = 1'b0;
    resetb      = 1'b0;
    step();
    resetb = 1'b1;
    rx.delete();
  endtask

  // One write cycle; the combinational RAM strobe is checked during it.
  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_ram);
    dmem_wready = 1'b1;
    dmem_waddr  = addr;
    dmem_wdata  = data;
    dmem_wstrb  = 4'hF;
    #1;
    check(tag, ram_wready, exp_ram);
    step();
    dmem_wready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " out_valid"},  out_valid,  0);
    check({tag, " out_data"},   out_data,   0);
    check({tag, " out_chan"},   out_chan,   0);
    check({tag, " exit_valid"}, exit_valid, 0);
    check({tag, " exit_code"},  exit_code,  0);
    check({tag, " timeout"},    timeout,    0);
    check({tag, " range_err"},  range_err,  0);
    check({tag, " err_addr"},   err_addr,   0);
    check({tag, " drop_cnt"},   drop_cnt,   0);
  endtask

  initial begin
    // ---- reset state
    step();
    do_reset();
    check_reset_vals("reset");

    // ---- console order
    out_ready = 1'b1;
    wr("con ram H", A_PUTC0, 32'h48, 1'b0);
    wr("con ram i", A_PUTC0, 32'h69, 1'b0);
    wr("con ram x", A_PUTC1, 32'h78, 1'b0);
    repeat (3) step();
    check("con count", rx.size(), 3);
    check("con beat0", rx[0], 16'h0048);
    check("con beat1", rx[1], 16'h0069);
    check("con beat2", rx[2], 16'h0178);
    check("con no drop", drop_cnt, 0);

    // ---- full FIFO: 16 kept, 4 dropped
    do_reset();
    for (int i = 0; i < 20; i++) wr("full ram", A_PUTC0, 32'h40 + i, 1'b0);
    check("full drop", drop_cnt, 4);
    check("full valid", out_valid, 1);
    check("full head", out_data, 8'h40);
    repeat (2) step();
    check("full hold", out_data, 8'h40);
    // Push while full, with a pop on the same edge: accepted.
    out_ready = 1'b1;
    wr("full pp ram", A_PUTC1, 32'hEE, 1'b0);
    repeat (20) step();
    check("full pp drop", drop_cnt, 4);
    check("full count", rx.size(), 17);
    check("full first", rx[0], 16'h0040);
    check("full last kept", rx[15], 16'h004F);
    check("full pp beat", rx[16], 16'h01EE);

    // ---- exit drain
    do_reset();
    wr("drn putc a", A_PUTC0, 32'h61, 1'b0);
    wr("drn putc b", A_PUTC0, 32'h62, 1'b0);
    wr("drn putc c", A_PUTC1, 32'h63, 1'b0);
    wr("drn exit ram", A_EXIT, 32'h2A, 1'b0);
    wr("drn late putc", A_PUTC0, 32'h7A, 1'b0);
    check("drn late no drop", drop_cnt, 0);
    check("drn code", exit_code, 32'h2A);
    check("drn not done", exit_valid, 0);
    out_ready = 1'b1;
    repeat (3) step();
    check("drn empty", out_valid, 0);
    check("drn still draining", exit_valid, 0);
    step();
    check("drn done", exit_valid, 1);
    check("drn code kept", exit_code, 32'h2A);
    check("drn timeout", timeout, 0);
    check("drn count", rx.size(), 3);
    check("drn beat0", rx[0], 16'h0061);
    check("drn beat2", rx[2], 16'h0163);

    // ---- watchdog: PC differs from reset prev-PC on the first edge,
    // then 100 increments, firing on the edge after count reaches 100.
    do_reset();
    pc_move = 1'b0;
    if_pc   = 32'h200;
    repeat (101) step();
    check("wd early", timeout, 0);
    step();
    check("wd fire", timeout, 1);
    check("wd code", exit_code, 32'hFFFF_FFFF);
    check("wd not done", exit_valid, 0);
    step();
    check("wd done", exit_valid, 1);

    // ---- watchdog with 50 stalled cycles
    do_reset();
    if_pc = 32'h300;
    repeat (10) step();
    stall = 1'b1;
    repeat (50) step();
    stall = 1'b0;
    repeat (91) step();
    check("wd stall early", timeout, 0);
    step();
    check("wd stall fire", timeout, 1);
    pc_move = 1'b1;

    // ---- range error
    do_reset();
    wr("rng legal ram", 32'h0000_0100, 32'h1, 1'b1);
    check("rng clean", range_err, 0);
    wr("rng first ram", 32'h0005_0000, 32'h2, 1'b1);
    wr("rng second ram", 32'h0006_0000, 32'h3, 1'b1);
    check("rng flag", range_err, 1);
    check("rng addr", err_addr, 32'h0005_0000);
    wr("rng claimed ram", BASE + 32'h1F0, 32'h4, 1'b0);

    // ---- reset mid-drain with 5 queued characters
    do_reset();
    for (int i = 0; i < 5; i++) wr("mid putc", A_PUTC0, 32'h30 + i, 1'b0);
    wr("mid rng", 32'h0005_0000, 32'h0, 1'b1);
    wr("mid exit", A_EXIT, 32'h7, 1'b0);
    check("mid queued", out_valid, 1);
    check("mid sticky", range_err, 1);
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    check_reset_vals("mid");
    // Back in RUN: EXIT with an empty FIFO completes two edges later.
    wr("mid exit2", A_EXIT, 32'h5, 1'b0);
    check("mid exit t+1", exit_valid, 0);
    step();
    check("mid exit t+2", exit_valid, 1);
    check("mid exit code", exit_code, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
